// File: rtl/window_gen_3x3_pkg.sv
// Shared image-processing definitions for the 3x3 window generator and its
// downstream filter stages.
package window_gen_3x3_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_TAPS = 9;
    localparam int WIN_W    = PIX_W * WIN_TAPS;

    // Byte positions inside the packed window, row-major from the top-left.
    localparam int TL     = 0;
    localparam int TC     = 1;
    localparam int TR     = 2;
    localparam int ML     = 3;
    localparam int CENTRE = 4;
    localparam int MR     = 5;
    localparam int BL     = 6;
    localparam int BC     = 7;
    localparam int BR     = 8;

    // One window column; element 0 is the oldest row (r-2), element 2 is row r.
    typedef logic [2:0][PIX_W-1:0] column_t;

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// One-row pixel store: combinational read of the addressed entry, with the
// write landing on the same edge (read-before-write).
module window_gen_3x3_line_buffer
    import window_gen_3x3_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [PIX_W-1:0] wdata_i,
    output logic [PIX_W-1:0] rdata_o
);

    // Sized to the full address range so every column address is in bounds.
    logic [PIX_W-1:0] mem_q [0:(1<<AW)-1];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Raster-stream 3x3 neighbourhood generator: two line buffers plus two column
// registers, emitting only windows that lie fully inside the frame.
module window_gen_3x3
    import window_gen_3x3_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sof,
    input  logic [PIX_W-1:0] i_pixel,
    input  logic             i_valid,
    output logic [WIN_W-1:0] pixel_data,
    output logic             pixel_data_valid
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] col_q, col_d, col_cur;
    logic [ROW_W-1:0] row_q, row_d, row_cur;
    logic             accept;
    logic             interior;
    logic [PIX_W-1:0] tap1, tap2;
    column_t          col_new, col_a_q, col_b_q;
    column_t          cols [3];
    logic [WIN_W-1:0] window_d;
    logic [WIN_W-1:0] pixel_data_q;
    logic             pixel_data_valid_q;

    assign accept = i_valid;

    // A start-of-frame pixel sits at (0,0) no matter where the counters are.
    always_comb begin
        col_cur  = i_sof ? '0 : col_q;
        row_cur  = i_sof ? '0 : row_q;
        interior = (row_cur >= ROW_W'(2)) && (col_cur >= COL_W'(2));
        if (col_cur == COL_LAST) begin
            col_d = '0;
            row_d = (row_cur == ROW_LAST) ? '0 : row_cur + ROW_W'(1);
        end else begin
            col_d = col_cur + COL_W'(1);
            row_d = row_cur;
        end
    end

    window_gen_3x3_line_buffer #(.AW(COL_W)) lb0 (
        .clk     (clk),
        .en_i    (accept),
        .addr_i  (col_cur),
        .wdata_i (i_pixel),
        .rdata_o (tap1)
    );

    window_gen_3x3_line_buffer #(.AW(COL_W)) lb1 (
        .clk     (clk),
        .en_i    (accept),
        .addr_i  (col_cur),
        .wdata_i (tap1),
        .rdata_o (tap2)
    );

    assign col_new = {i_pixel, tap1, tap2};
    assign cols[0] = col_a_q;
    assign cols[1] = col_b_q;
    assign cols[2] = col_new;

    generate
        for (genvar gi = 0; gi < WIN_TAPS; gi++) begin : g_pack
            assign window_d[gi*PIX_W +: PIX_W] = cols[gi % 3][gi / 3];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q              <= '0;
            row_q              <= '0;
            col_a_q            <= '0;
            col_b_q            <= '0;
            pixel_data_q       <= '0;
            pixel_data_valid_q <= 1'b0;
        end else if (accept) begin
            col_q              <= col_d;
            row_q              <= row_d;
            col_a_q            <= col_b_q;
            col_b_q            <= col_new;
            pixel_data_valid_q <= interior;
            if (interior) begin
                pixel_data_q <= window_d;
            end
        end else begin
            pixel_data_valid_q <= 1'b0;
        end
    end

    assign pixel_data       = pixel_data_q;
    assign pixel_data_valid = pixel_data_valid_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 on a 4x4 image, against a frame-array
// reference model.
module tb_window_gen_3x3;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_sof = 1'b0;
    logic        i_valid = 1'b0;
    logic [7:0]  i_pixel = 8'h00;
    logic [71:0] pixel_data;
    logic        pixel_data_valid;

    int n_cmp = 0;
    int n_bad = 0;

    logic [71:0] got [$];

    always #5 clk = ~clk;

    window_gen_3x3 #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .COL_W      (2),
        .ROW_W      (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_sof            (i_sof),
        .i_pixel          (i_pixel),
        .i_valid          (i_valid),
        .pixel_data       (pixel_data),
        .pixel_data_valid (pixel_data_valid)
    );

    // ---------------- reference model ----------------
    logic [7:0]  img [H][W];
    int          m_row, m_col;
    int          cur_r, cur_c;
    logic        exp_valid;
    logic [71:0] exp_data;

    assign cur_r = i_sof ? 0 : m_row;
    assign cur_c = i_sof ? 0 : m_col;

    function automatic logic [71:0] model_win(input int r, input int c, input logic [7:0] p);
        logic [71:0] w;
        logic [7:0]  v;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (i == 2 && j == 2) v = p;
                else                  v = img[r-2+i][c-2+j];
                w[(i*3+j)*8 +: 8] = v;
            end
        end
        return w;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_row     <= 0;
            m_col     <= 0;
            exp_valid <= 1'b0;
            exp_data  <= '0;
        end else begin
            exp_valid <= 1'b0;
            if (i_valid) begin
                img[cur_r][cur_c] <= i_pixel;
                if (cur_r >= 2 && cur_c >= 2) begin
                    exp_valid <= 1'b1;
                    exp_data  <= model_win(cur_r, cur_c, i_pixel);
                end
                if (cur_c == W-1) begin
                    m_col <= 0;
                    m_row <= (cur_r == H-1) ? 0 : cur_r + 1;
                end else begin
                    m_col <= cur_c + 1;
                    m_row <= cur_r;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk_win(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk_int("valid", int'(pixel_data_valid), int'(exp_valid));
        chk_win("data", pixel_data, exp_data);
        if (pixel_data_valid) begin
            got.push_back(pixel_data);
            $display("window %0d: %h", got.size(), pixel_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] p);
        i_valid = v;
        i_sof   = s;
        i_pixel = p;
        step();
    endtask

    task automatic idle(input int n, input logic s);
        for (int k = 0; k < n; k++) drive(1'b0, s, 8'($urandom));
    endtask

    // mode 0: continuous, 1: valid,0,0 pattern, 2: random gaps, 3: idle with i_sof=1
    task automatic send_pix(input logic [7:0] p, input logic s, input int mode);
        drive(1'b1, s, p);
        case (mode)
            1:       idle(2, 1'b0);
            2:       idle(int'($urandom_range(0, 3)), 1'b0);
            3:       idle(1, 1'b1);
            default: ;
        endcase
    endtask

    task automatic send_frame(input logic [7:0] base, input int mode, input bit randpix, input int npix);
        logic [7:0] p;
        for (int idx = 0; idx < npix; idx++) begin
            p = randpix ? 8'($urandom) : base + 8'((idx / W) * 16 + (idx % W));
            send_pix(p, idx == 0, mode);
        end
    endtask

    localparam logic [71:0] F1_FIRST = 72'h22_21_20_12_11_10_02_01_00;
    localparam logic [71:0] F1_LAST  = 72'h33_32_31_23_22_21_13_12_11;
    localparam logic [71:0] F2_FIRST = 72'hA2_A1_A0_92_91_90_82_81_80;

    initial begin
        #1 rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_win("reset_data", pixel_data, 72'h0);
        chk_int("reset_valid", int'(pixel_data_valid), 0);

        // Continuous frame
        got.delete();
        send_frame(8'h00, 0, 1'b0, W*H);
        idle(3, 1'b0);
        chk_int("cont_count", got.size(), 4);
        chk_win("cont_first", got[0], F1_FIRST);
        chk_win("cont_last", got[3], F1_LAST);

        // Toggling valid
        got.delete();
        send_frame(8'h00, 1, 1'b0, W*H);
        idle(3, 1'b0);
        chk_int("gap_count", got.size(), 4);
        chk_win("gap_first", got[0], F1_FIRST);
        chk_win("gap_last", got[3], F1_LAST);

        // Back-to-back frames
        got.delete();
        send_frame(8'h00, 0, 1'b0, W*H);
        send_frame(8'h80, 0, 1'b0, W*H);
        idle(3, 1'b0);
        chk_int("b2b_count", got.size(), 8);
        chk_win("b2b_f2_first", got[4], F2_FIRST);

        // Start of frame arriving at (2,1) of the previous frame
        got.delete();
        send_frame(8'h00, 0, 1'b0, 2*W + 1);
        send_frame(8'h80, 0, 1'b0, W*H);
        idle(3, 1'b0);
        chk_int("sofmid_count", got.size(), 4);
        chk_win("sofmid_first", got[0], F2_FIRST);

        // Asynchronous reset in the middle of row 2
        send_frame(8'h00, 0, 1'b0, 2*W + 3);
        #2 rst = 1'b1;
        #1;
        chk_int("arst_valid", int'(pixel_data_valid), 0);
        chk_win("arst_data", pixel_data, 72'h0);
        step();
        rst = 1'b0;
        got.delete();
        send_frame(8'h00, 0, 1'b0, W*H);
        idle(3, 1'b0);
        chk_int("arst_count", got.size(), 4);
        chk_win("arst_first", got[0], F1_FIRST);
        chk_win("arst_last", got[3], F1_LAST);

        // i_sof without i_valid is ignored
        got.delete();
        send_frame(8'h00, 3, 1'b0, W*H);
        idle(3, 1'b0);
        chk_int("sofidle_count", got.size(), 4);
        chk_win("sofidle_first", got[0], F1_FIRST);
        chk_win("sofidle_last", got[3], F1_LAST);

        // Random-pixel frames with random gaps
        for (int f = 0; f < 4; f++) begin
            got.delete();
            send_frame(8'h00, 2, 1'b1, W*H);
            idle(3, 1'b0);
            chk_int("rand_count", got.size(), 4);
        end

        // Free-running random stream with occasional start-of-frame
        for (int k = 0; k < 300; k++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0), 8'($urandom));
        end
        idle(3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
